// File: rtl/stm32_iq_stream.sv
// STM32 parallel-bus RX IQ streamer: N-channel sample FIFO, gapless per-channel
// framing onto an 8-bit bus, and an overflow/underflow status readout.
module stm32_iq_stream #(
  parameter int          CHANNELS     = 2,
  parameter int          SAMPLE_BYTES = 4,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [7:0]  CMD_STREAM   = 8'd4,
  parameter logic [7:0]  CMD_STATUS   = 8'd8,
  parameter logic [7:0]  CMD_CLEAR    = 8'd9
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic                                  IQ_valid,
  input  logic [CHANNELS*2*SAMPLE_BYTES*8-1:0]  IQ_data,
  input  logic [CHANNELS-1:0]                   ch_enable,
  input  logic                                  DATA_SYNC,
  input  logic [7:0]                            DATA_BUS_IN,
  output logic [7:0]                            DATA_BUS_OUT,
  output logic                                  DATA_BUS_OE,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_level,
  output logic [15:0]                           overflow_count,
  output logic [15:0]                           underflow_count
);

  localparam int SLICE_W   = 2 * SAMPLE_BYTES * 8;
  localparam int DW        = CHANNELS * SLICE_W;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int LVL_W     = PTR_W + 1;
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BI_W      = $clog2(2 * SAMPLE_BYTES);
  localparam int LAST_BYTE = 2 * SAMPLE_BYTES - 1;

  typedef enum logic [1:0] {IDLE, STREAM, STATUS} state_t;

  function automatic logic [CH_W-1:0] first_ch(input logic [CHANNELS-1:0] en);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int c = CHANNELS - 1; c >= 0; c--)
      if (en[c]) idx = CH_W'(c);
    return idx;
  endfunction

  // Returns {found, index} of the lowest enabled channel above cur.
  function automatic logic [CH_W:0] next_ch(input logic [CHANNELS-1:0] en,
                                            input logic [CH_W-1:0]     cur);
    logic            found;
    logic [CH_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int c = CHANNELS - 1; c >= 0; c--)
      if (en[c] && c > int'(cur)) begin
        found = 1'b1;
        idx   = CH_W'(c);
      end
    return {found, idx};
  endfunction

  // Q sits above I in each slice, so the MSB-first Q-then-I order is simply
  // the slice bytes walked from the top down.
  function automatic logic [7:0] pick_byte(input logic [DW-1:0]   data,
                                           input logic [CH_W-1:0] ch,
                                           input logic [BI_W-1:0] bi);
    logic [DW-1:0] sh;
    sh = data >> (int'(ch) * SLICE_W + (LAST_BYTE - int'(bi)) * 8);
    return sh[7:0];
  endfunction

  state_t                state_q, state_d;
  logic [DW-1:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [DW-1:0]         hold_q, hold_d;
  logic [CHANNELS-1:0]   en_q, en_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [BI_W-1:0]       bi_q, bi_d;
  logic [2:0]            st_idx_q, st_idx_d;
  logic [15:0]           snap_ovf_q, snap_ovf_d, snap_unf_q, snap_unf_d;
  logic [7:0]            out_d;
  logic                  oe_d, clear_ctr;

  logic                  full, empty, push, pop, drop, frame_start, frame_last;
  logic [CH_W:0]         nxt;
  logic [CH_W-1:0]       start_ch;
  logic [DW-1:0]         start_sample;
  logic [CHANNELS-1:0]   en_src;

  assign full         = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign empty        = (fifo_level == '0);
  assign en_src       = DATA_SYNC ? ch_enable : en_q;
  assign start_ch     = first_ch(en_src);
  assign start_sample = empty ? '0 : mem[rd_ptr];
  assign nxt          = next_ch(en_q, ch_q);
  assign frame_last   = (bi_q == BI_W'(LAST_BYTE)) && !nxt[CH_W];
  assign frame_start  = (DATA_SYNC && DATA_BUS_IN == CMD_STREAM && |ch_enable) ||
                        (!DATA_SYNC && state_q == STREAM && |en_q && frame_last);
  assign pop          = frame_start && !empty;
  assign push         = IQ_valid && (!full || pop);
  assign drop         = IQ_valid && full && !pop;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    out_d      = DATA_BUS_OUT;
    oe_d       = DATA_BUS_OE;
    en_d       = en_q;
    ch_d       = ch_q;
    bi_d       = bi_q;
    hold_d     = hold_q;
    st_idx_d   = st_idx_q;
    snap_ovf_d = snap_ovf_q;
    snap_unf_d = snap_unf_q;
    clear_ctr  = 1'b0;
    if (DATA_SYNC) begin
      case (DATA_BUS_IN)
        CMD_STREAM: begin
          state_d = STREAM;
          oe_d    = 1'b1;
          en_d    = ch_enable;
          ch_d    = start_ch;
          bi_d    = '0;
          out_d   = 8'h00;
          if (frame_start) begin
            hold_d = start_sample;
            out_d  = pick_byte(start_sample, start_ch, '0);
          end
        end
        CMD_STATUS: begin
          state_d    = STATUS;
          oe_d       = 1'b1;
          out_d      = 8'(fifo_level);
          st_idx_d   = 3'd1;
          snap_ovf_d = overflow_count;
          snap_unf_d = underflow_count;
        end
        CMD_CLEAR: begin
          state_d   = IDLE;
          oe_d      = 1'b0;
          out_d     = 8'h00;
          clear_ctr = 1'b1;
        end
        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
          out_d   = 8'h00;
        end
      endcase
    end else begin
      case (state_q)
        STREAM: begin
          if (!(|en_q)) begin
            out_d = 8'h00;
          end else if (frame_last) begin
            hold_d = start_sample;
            ch_d   = start_ch;
            bi_d   = '0;
            out_d  = pick_byte(start_sample, start_ch, '0);
          end else if (bi_q == BI_W'(LAST_BYTE)) begin
            ch_d  = nxt[CH_W-1:0];
            bi_d  = '0;
            out_d = pick_byte(hold_q, nxt[CH_W-1:0], '0);
          end else begin
            bi_d  = bi_q + 1'b1;
            out_d = pick_byte(hold_q, ch_q, bi_q + 1'b1);
          end
        end
        STATUS: begin
          case (st_idx_q)
            3'd1:    out_d = snap_ovf_q[15:8];
            3'd2:    out_d = snap_ovf_q[7:0];
            3'd3:    out_d = snap_unf_q[15:8];
            3'd4:    out_d = snap_unf_q[7:0];
            default: out_d = 8'h00;
          endcase
          if (st_idx_q != 3'd5) st_idx_d = st_idx_q + 3'd1;
        end
        default: begin
          out_d = 8'h00;
          oe_d  = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q         <= IDLE;
      DATA_BUS_OUT    <= 8'h00;
      DATA_BUS_OE     <= 1'b0;
      en_q            <= '0;
      ch_q            <= '0;
      bi_q            <= '0;
      hold_q          <= '0;
      st_idx_q        <= '0;
      snap_ovf_q      <= '0;
      snap_unf_q      <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_level      <= '0;
      overflow_count  <= '0;
      underflow_count <= '0;
    end else begin
      state_q      <= state_d;
      DATA_BUS_OUT <= out_d;
      DATA_BUS_OE  <= oe_d;
      en_q         <= en_d;
      ch_q         <= ch_d;
      bi_q         <= bi_d;
      hold_q       <= hold_d;
      st_idx_q     <= st_idx_d;
      snap_ovf_q   <= snap_ovf_d;
      snap_unf_q   <= snap_unf_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (clear_ctr) begin
        overflow_count  <= '0;
        underflow_count <= '0;
      end else begin
        if (drop && overflow_count != 16'hFFFF)
          overflow_count <= overflow_count + 16'd1;
        if (frame_start && empty && underflow_count != 16'hFFFF)
          underflow_count <= underflow_count + 16'd1;
      end
    end
  end

  // NOTE: the sample storage is deliberately not reset; the pointers and
  // level define which entries are valid.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= IQ_data;
  end

endmodule

// File: doc/stm32_iq_stream.md
Name: stm32_iq_stream

Overview:
Parametrised successor of the STM32 parallel-bus RX IQ path. Buffers N-channel IQ samples in a true FIFO with full/empty tracking, and streams per-channel enabled frames over the 8-bit STM32 bus. Also provides a status/counter readout for overflow and underflow. Sits between the DDC outputs and the bus pins; the tristate pad is resolved at top level from DATA_BUS_OE.

Parameters:
CHANNELS, 2, number of RX channels (1..4).
SAMPLE_BYTES, 4, bytes per I or Q word (2..4), sent MSB first.
FIFO_DEPTH, 8, FIFO entries; power of two, 4..64.
CMD_STREAM, 8'd4, bus opcode that starts IQ streaming.
CMD_STATUS, 8'd8, bus opcode that starts the status readout.
CMD_CLEAR, 8'd9, bus opcode that clears the counters.

Ports:
clk_in  in  1  bus/system clock; sole clock.
reset_in  in  1  synchronous, active-high reset.
IQ_valid  in  1  one-cycle strobe: IQ_data holds a new sample set.
IQ_data  in  CHANNELS*2*SAMPLE_BYTES*8  channel c occupies slice c. Within each slice, Q is in the upper half and I in the lower half.
ch_enable  in  CHANNELS  per-channel stream enable.
DATA_SYNC  in  1  command strobe; DATA_BUS_IN carries the opcode.
DATA_BUS_IN  in  8  bus input byte.
DATA_BUS_OUT  out  8  registered output byte.
DATA_BUS_OE  out  1  1 = FPGA drives the bus.
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow_count  out  16  samples dropped because the FIFO was full; saturates at 16'hFFFF.
underflow_count  out  16  frames started while the FIFO was empty; saturates at 16'hFFFF.

Behaviour:
- Reset state: DATA_BUS_OUT=0, DATA_BUS_OE=0, FSM=IDLE, FIFO empty, fifo_level=0, both counters=0, hold register=0.
- FIFO push: on IQ_valid when not full, push the whole IQ_data vector.
- Push when full: drop the sample; overflow_count++.
- Push and pop in the same cycle while full: both are accepted and the level is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, STREAM, STATUS.
- DATA_SYNC=1 has priority over any state.
  - CMD_STREAM: latch ch_enable into en_q; OE=1; start a frame on this edge.
  - CMD_STATUS: OE=1; status byte 0 is loaded.
  - CMD_CLEAR: zero both counters; OE=0; go to IDLE.
  - Any other opcode: OE=0; go to IDLE.
- DATA_SYNC mid-frame aborts the frame. An already popped sample is discarded, not re-queued.
- Frame start, FIFO non-empty: pop into the hold register.
- Frame start, FIFO empty: load the hold register with zeros; underflow_count++.
- Frame layout: enabled channels in ascending index order. Per channel: Q bytes MSB..LSB, then I bytes MSB..LSB. Frame length = popcount(en_q)*2*SAMPLE_BYTES bytes.
- One byte per clk_in edge. DATA_BUS_OUT shows frame byte 0 on the edge that starts the frame. The edge after the last byte starts the next frame (gapless, continuous).
- If en_q is all zero: output 8'h00 every cycle, no pops, no underflow counting.
- STATUS byte sequence: fifo_level (zero-extended/truncated to 8 bits), overflow_count[15:8], overflow_count[7:0], underflow_count[15:8], underflow_count[7:0], then 8'h00 repeated until the next DATA_SYNC.
- Counters are snapshotted at STATUS entry, so the readout is coherent.
- Reset mid-operation: return to the reset state on the next edge, regardless of DATA_SYNC.

Test Plan:
- CHANNELS=2, SAMPLE_BYTES=4, en=2'b11. Push Q0=32'h11223344, I0=32'h55667788, Q1=32'h99AABBCC, I1=32'hDDEEFF00, then CMD_STREAM -> bytes 11 22 33 44 55 66 77 88 99 AA BB CC DD EE FF 00 on consecutive edges; fifo_level 1->0.
- en=2'b10 with the same sample -> 8-byte frame 99 AA BB CC DD EE FF 00 only.
- 10 strobes with no reads (DEPTH=8) -> fifo_level=8, overflow_count=2. CMD_STATUS -> 08 00 02 00 00 then 00s.
- Stream with the FIFO empty for 3 frame starts -> 48 bytes of 00, underflow_count=3. CMD_CLEAR -> both counters 0, OE=0.
- FIFO full, IQ_valid coincides with a frame-start pop -> level stays 8, overflow_count unchanged.
- Assert reset_in on byte 5 of a frame -> next edge OE=0, DATA_BUS_OUT=0, level=0. A subsequent CMD_STREAM produces an all-zero frame and underflow_count=1.
